// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//     - pause vector bit indices (PC, IF, ID, EX, MEM, WB)
//     - controller state encoding (2 bits)
//     - reset PC and default exception drain length
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    // Bit positions inside the pause[5:0] vector, one per pipeline register.
    localparam int PAUSE_PC  = 0;
    localparam int PAUSE_IF  = 1;
    localparam int PAUSE_ID  = 2;
    localparam int PAUSE_EX  = 3;
    localparam int PAUSE_MEM = 4;
    localparam int PAUSE_WB  = 5;
    localparam int PAUSE_W   = 6;

    // PC value presented while in reset and the initial pending PC.
    localparam logic [31:0] RESET_PC = 32'h1C00_0000;

    // Cycles fetch is held after an exception flush (legal range 1..15).
    localparam int DEFAULT_FLUSH_HOLD = 2;
    localparam int HOLD_CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_REDIR_PEND = 2'd1,
        ST_EXC_HOLD   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_pause_encoder.sv
// -----------------------------------------------------------------------------
// pause_encoder
//   Merges the per-stage stall requests into the pause vector. The highest
//   requesting stage wins and freezes itself plus every stage in front of it,
//   which yields a thermometer code. The hold flag additionally freezes PC and
//   IF (used while the pipeline drains after an exception).
//
// Ports
//   stall_req_if  : I-cache miss / fetch not ready
//   stall_req_id  : load-use hazard
//   stall_req_ex  : multi-cycle mul/div busy
//   stall_req_mem : D-cache miss
//   hold          : force PC and IF paused
//   pause[5:0]    : per-stage hold vector (bit 0 PC .. bit 5 WB)
// -----------------------------------------------------------------------------
module pause_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic               stall_req_if,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               stall_req_mem,
    input  logic               hold,
    output logic [PAUSE_W-1:0] pause
);

    logic any_stall;

    assign any_stall = stall_req_if | stall_req_id | stall_req_ex | stall_req_mem;

    // Each bit is set when the requesting stage is at or beyond that stage.
    // WB never stalls: a stage is only paused by itself or a later stage, and
    // nothing sits after WB.
    always_comb begin
        pause            = '0;
        pause[PAUSE_PC]  = any_stall | hold;
        pause[PAUSE_IF]  = any_stall | hold;
        pause[PAUSE_ID]  = stall_req_id | stall_req_ex | stall_req_mem;
        pause[PAUSE_EX]  = stall_req_ex | stall_req_mem;
        pause[PAUSE_MEM] = stall_req_mem;
        pause[PAUSE_WB]  = 1'b0;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush controller for the six-stage pipeline. Produces the
//   pause vector, the branch and exception flushes and the PC redirect. A
//   small FSM remembers a branch redirect that resolved while fetch was
//   stalled (REDIR_PEND) and holds fetch for FLUSH_HOLD cycles after an
//   exception (EXC_HOLD).
//
//   All outputs are combinational from the inputs and the registered state,
//   so a redirect or flush takes effect in the cycle its cause is seen.
//   Priority: exception > pending/new branch > stalls.
//
// Parameters
//   FLUSH_HOLD       : cycles fetch is held after an exception (1..15)
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   stall_req_*      : per-stage stall requests (if, id, ex, mem)
//   branch_valid     : EX resolved a mispredicted branch this cycle
//   branch_target    : correct-path PC for that branch
//   exception_valid  : commit raised an exception or ertn
//   exception_target : handler / era PC
//   pause[5:0]       : per-stage hold vector
//   branch_flush     : kill IF/ID and ID/EX contents
//   exception_flush  : kill all pipeline registers
//   redirect_valid   : load redirect_pc into PC this cycle
//   redirect_pc      : redirect address
//   fsm_state        : current controller state (observation only)
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_HOLD = DEFAULT_FLUSH_HOLD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_req_if,
    input  logic               stall_req_id,
    input  logic               stall_req_ex,
    input  logic               stall_req_mem,
    input  logic               branch_valid,
    input  logic [31:0]        branch_target,
    input  logic               exception_valid,
    input  logic [31:0]        exception_target,
    output logic [PAUSE_W-1:0] pause,
    output logic               branch_flush,
    output logic               exception_flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [1:0]         fsm_state
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(FLUSH_HOLD);

    ctrl_state_t             state;
    logic [31:0]             pend_pc;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [PAUSE_W-1:0]      stall_pause;
    logic                    in_hold;

    assign in_hold   = (state == ST_EXC_HOLD);
    assign fsm_state = state;

    pause_encoder u_pause_encoder (
        .stall_req_if  (stall_req_if),
        .stall_req_id  (stall_req_id),
        .stall_req_ex  (stall_req_ex),
        .stall_req_mem (stall_req_mem),
        .hold          (in_hold),
        .pause         (stall_pause)
    );

    // Output decode. Reset forces everything quiet; an exception wins over
    // any branch activity and releases the pause vector so the flush can
    // clear every register in the same cycle.
    always_comb begin
        pause           = '0;
        branch_flush    = 1'b0;
        exception_flush = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = pend_pc;

        if (rst) begin
            redirect_pc = RESET_PC;
        end else if (exception_valid) begin
            exception_flush = 1'b1;
            redirect_valid  = 1'b1;
            redirect_pc     = exception_target;
        end else begin
            pause = stall_pause;
            case (state)
                ST_RUN: begin
                    // While EX itself is frozen the branch will be presented
                    // again, so it is only acted on once EX is moving.
                    if (branch_valid && !stall_pause[PAUSE_EX]) begin
                        branch_flush = 1'b1;
                        if (!stall_pause[PAUSE_PC]) begin
                            redirect_valid = 1'b1;
                            redirect_pc    = branch_target;
                        end
                    end
                end
                ST_REDIR_PEND: begin
                    // Keep squashing wrong-path fetches until PC can load.
                    branch_flush = 1'b1;
                    if (!stall_pause[PAUSE_PC]) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = pend_pc;
                    end
                end
                default: begin
                    // EXC_HOLD: fetch hold is already folded into stall_pause.
                end
            endcase
        end
    end

    // Controller FSM with the pending PC and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pend_pc  <= RESET_PC;
            hold_cnt <= '0;
        end else if (exception_valid) begin
            // Any state: abandon pending work and (re)start the drain.
            state    <= ST_EXC_HOLD;
            hold_cnt <= HOLD_LOAD;
        end else begin
            case (state)
                ST_RUN: begin
                    if (branch_valid && !stall_pause[PAUSE_EX] && stall_pause[PAUSE_PC]) begin
                        pend_pc <= branch_target;
                        state   <= ST_REDIR_PEND;
                    end
                end
                ST_REDIR_PEND: begin
                    if (!stall_pause[PAUSE_PC]) begin
                        state <= ST_RUN;
                    end
                end
                ST_EXC_HOLD: begin
                    // The cycle that sees a count of 1 is the last hold cycle.
                    if (hold_cnt <= HOLD_CNT_W'(1)) begin
                        state    <= ST_RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios followed by random traffic for pipeline_ctrl. Expected
//   outputs come from a behavioural model that tracks "cycles of fetch hold
//   left" and "is a branch redirect owed" and applies the controller rules
//   cycle by cycle.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int HOLD = 2;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
    logic        branch_valid, exception_valid;
    logic [31:0] branch_target, exception_target;
    logic [5:0]  pause;
    logic        branch_flush, exception_flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    pipeline_ctrl #(.FLUSH_HOLD(HOLD)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_req_if     (stall_req_if),
        .stall_req_id     (stall_req_id),
        .stall_req_ex     (stall_req_ex),
        .stall_req_mem    (stall_req_mem),
        .branch_valid     (branch_valid),
        .branch_target    (branch_target),
        .exception_valid  (exception_valid),
        .exception_target (exception_target),
        .pause            (pause),
        .branch_flush     (branch_flush),
        .exception_flush  (exception_flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fsm_state        (fsm_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int          m_hold_left = 0;   // hold cycles still to come
    bit          m_owed      = 0;   // a branch redirect is still owed
    logic [31:0] m_owed_pc   = RESET_PC;

    // Highest stalling stage s freezes stages 0..s; mem=4, ex=3, id=2, if=1.
    function automatic logic [5:0] stall_code(input bit sif, sid, sex, smem);
        int n;
        n = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        return 6'((1 << n) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one cycle ----------------
    task automatic cyc(input bit r, input bit sif, input bit sid, input bit sex, input bit smem,
                       input bit bv, input logic [31:0] bt, input bit ev, input logic [31:0] et);
        logic [5:0]  e_pause, code;
        logic        e_bf, e_ef, e_rv;
        logic [31:0] e_pc;
        logic [1:0]  e_st;

        @(negedge clk);
        rst = r;
        stall_req_if = sif; stall_req_id = sid; stall_req_ex = sex; stall_req_mem = smem;
        branch_valid = bv; branch_target = bt;
        exception_valid = ev; exception_target = et;
        #1;

        code    = stall_code(sif, sid, sex, smem);
        e_pause = '0; e_bf = 0; e_ef = 0; e_rv = 0; e_pc = RESET_PC;
        e_st    = (m_hold_left > 0) ? 2'(ST_EXC_HOLD) : m_owed ? 2'(ST_REDIR_PEND) : 2'(ST_RUN);

        if (!r) check("state", 32'(fsm_state), 32'(e_st));

        if (r) begin
            m_hold_left = 0;
            m_owed      = 0;
            m_owed_pc   = RESET_PC;
        end else if (ev) begin
            e_ef = 1; e_rv = 1; e_pc = et;
            m_hold_left = HOLD;
            m_owed      = 0;
        end else if (m_hold_left > 0) begin
            e_pause = code | 6'b000011;
            m_hold_left--;
        end else if (m_owed) begin
            e_pause = code;
            e_bf    = 1;
            if (!code[0]) begin
                e_rv = 1; e_pc = m_owed_pc;
                m_owed = 0;
            end
        end else begin
            e_pause = code;
            if (bv && !code[3]) begin
                e_bf = 1;
                if (!code[0]) begin
                    e_rv = 1; e_pc = bt;
                end else begin
                    m_owed = 1; m_owed_pc = bt;
                end
            end
        end

        check("pause", 32'(pause), 32'(e_pause));
        check("branch_flush", 32'(branch_flush), 32'(e_bf));
        check("exception_flush", 32'(exception_flush), 32'(e_ef));
        check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        if (r || e_rv) check("redirect_pc", redirect_pc, e_pc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0; stall_req_mem = 0;
        branch_valid = 0; branch_target = '0; exception_valid = 0; exception_target = '0;

        // Reset
        cyc(1, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(1, 1,1,1,1, 1, 32'h1C00_0040, 1, 32'h1C00_8000);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Stall encoding
        cyc(0, 1,1,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,1, 0, 32'h0, 0, 32'h0);
        cyc(0, 1,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,1,0, 0, 32'h0, 0, 32'h0);

        // Branch with fetch free
        cyc(0, 0,0,0,0, 1, 32'h1C00_0100, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Branch ignored while EX is frozen
        cyc(0, 0,0,1,0, 1, 32'h1C00_0180, 0, 32'h0);

        // Branch during I-miss: 3 stalled cycles, wrong-path branch ignored
        cyc(0, 1,0,0,0, 1, 32'h1C00_0200, 0, 32'h0);
        cyc(0, 1,0,0,0, 1, 32'h1C00_0AAA, 0, 32'h0);
        cyc(0, 1,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Exception over branch, then the hold window
        cyc(0, 0,0,0,0, 1, 32'h1C00_0400, 1, 32'h1C00_8000);
        cyc(0, 0,0,0,0, 1, 32'h1C00_0404, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Exception while a redirect is pending
        cyc(0, 1,0,0,0, 1, 32'h1C00_0300, 0, 32'h0);
        cyc(0, 1,0,0,0, 0, 32'h0, 1, 32'h1C00_8000);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Exception during hold reloads the window
        cyc(0, 0,0,0,0, 0, 32'h0, 1, 32'h1C00_9000);
        cyc(0, 0,0,0,0, 0, 32'h0, 1, 32'h1C00_9100);
        cyc(0, 0,1,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Reset mid-hold
        cyc(0, 0,0,0,0, 0, 32'h0, 1, 32'h1C00_8000);
        cyc(1, 0,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Reset mid-pending
        cyc(0, 1,0,0,0, 1, 32'h1C00_0500, 0, 32'h0);
        cyc(1, 1,0,0,0, 0, 32'h0, 0, 32'h0);
        cyc(0, 0,0,0,0, 0, 32'h0, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(63) == 0),
                ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                ($urandom_range(5) == 0), ($urandom_range(7) == 0),
                ($urandom_range(3) == 0), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(15) == 0), $urandom & 32'hFFFF_FFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the six-stage front/back-end pipeline. It merges per-stage stall requests into the `pause[5:0]` vector consumed by every pipeline register: bit 0 is PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB. It also drives `branch_flush` and `exception_flush`, and owns the PC redirect. A small FSM holds branch redirects that resolve while fetch is stalled, and holds fetch for a fixed drain period after an exception.

## Interface

- `FLUSH_HOLD`, default 2: cycles fetch is held after an exception flush, range 1..15.
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `stall_req_if` in, 1: I-cache miss / fetch not ready.
- `stall_req_id` in, 1: load-use hazard.
- `stall_req_ex` in, 1: multi-cycle mul/div busy.
- `stall_req_mem` in, 1: D-cache miss.
- `branch_valid` in, 1: EX resolved a mispredicted branch this cycle.
- `branch_target` in, 32: correct-path PC.
- `exception_valid` in, 1: commit stage raised an exception or ertn.
- `exception_target` in, 32: handler or era PC.
- `pause` out, 6: per-stage hold vector.
- `branch_flush` out, 1: kill IF/ID and ID/EX contents.
- `exception_flush` out, 1: kill all pipeline registers.
- `redirect_valid` out, 1: load `redirect_pc` into PC this cycle.
- `redirect_pc` out, 32: redirect address.

## Operation

- **Pause encoding**, highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
  - When `pause[k]` is set and `pause[k+1]` is clear, the register after stage k inserts a bubble.
- **States:** RUN, REDIR_PEND, EXC_HOLD.
- **RUN**
  - `exception_valid`:
    - `exception_flush`=1, `redirect_valid`=1, `redirect_pc`=`exception_target`, `pause`=0, all in the same cycle.
    - Load counter with `FLUSH_HOLD` and go to EXC_HOLD.
  - `branch_valid` with `pause[3]`=0:
    - `branch_flush`=1.
    - If `pause[0]`=0: `redirect_valid`=1, `redirect_pc`=`branch_target`, stay in RUN.
    - Else latch `branch_target` into `pend_pc` and go to REDIR_PEND.
  - `branch_valid` with `pause[3]`=1 is ignored; the branch is re-presented.
- **REDIR_PEND**
  - `branch_flush` is held at 1 every cycle.
  - When `pause[0]`=0: `redirect_valid`=1, `redirect_pc`=`pend_pc`, go to RUN.
  - `branch_valid` is ignored (wrong path).
  - `exception_valid` overrides: drop `pend_pc`, take the exception path as in RUN.
- **EXC_HOLD**
  - `pause` = stall-encoded vector OR 6'b000011.
  - Counter decrements each cycle; when it reaches 1, return to RUN on the next edge.
  - `branch_valid` is ignored.
  - A new `exception_valid` takes the exception path again: new redirect, counter reloaded.
- **Priority:** `exception_valid` > pending/new branch > stalls. `exception_flush` and `branch_flush` are never asserted together; the exception wins.

## Timing

- `pause`, flushes and redirect are combinational from the inputs and the registered state; zero-cycle latency.
- State, `pend_pc` and counter update on the posedge.
- While `rst`=1:
  - All outputs are 0 and `redirect_pc`=32'h1C000000.
  - State RUN, `pend_pc`=32'h1C000000, counter 0.
- Reset mid-REDIR_PEND or mid-EXC_HOLD abandons the pending redirect or hold; there is no redirect after reset.
- EXC_HOLD lasts exactly `FLUSH_HOLD` cycles after the exception cycle.
- A redirect from REDIR_PEND fires in the first cycle `pause[0]`=0, never earlier.

## Structure

- `define.v` additions:
  - pause bit indices (`PAUSE_PC`..`PAUSE_WB`)
  - state encodings (2 bits)
  - reset PC 32'h1C000000
  - default `FLUSH_HOLD`
- One combinational sub-module, `pause_encoder`: four stall requests plus a hold flag in, `pause[5:0]` out. FSM and registers stay in `pipeline_ctrl`.

## Test plan

- **Stall encoding:** `stall_req_id`=1 and `stall_req_if`=1 → `pause`=6'b000111. `stall_req_mem` alone → 6'b011111.
- **Branch, fetch free:** `branch_valid`, `branch_target`=0x1C000100, no stalls → same cycle `branch_flush`=1, `redirect_valid`=1, `redirect_pc`=0x1C000100; state stays RUN.
- **Branch during I-miss:**
  - `stall_req_if` held 3 cycles while `branch_valid`, target 0x1C000200 → `branch_flush` high for all 3 cycles, no redirect.
  - The cycle `stall_req_if` drops → `redirect_valid`=1, `redirect_pc`=0x1C000200.
- **Exception over branch:** same-cycle `exception_valid` (0x1C008000) and `branch_valid` → `exception_flush`=1, `branch_flush`=0, `redirect_pc`=0x1C008000, `pause`=0. The next 2 cycles `pause`=6'b000011, then 0.
- **Exception in REDIR_PEND:** pending 0x1C000300, then `exception_valid` to 0x1C008000 → redirect to 0x1C008000 only; 0x1C000300 is never issued.
- **Reset mid-EXC_HOLD:** assert `rst` on hold cycle 1 → the next cycle has all outputs 0 and RUN.
